// File: rtl/adc_stim_sequencer.sv
// Table-driven ADC stimulus source: replays up to SEG segments of per-channel
// sample values and valid flags, each held for a programmed number of clocks.
module adc_stim_sequencer #(
  parameter int DW  = 14,
  parameter int CH  = 2,
  parameter int SEG = 8,
  parameter int CW  = 32
) (
  input  logic                    adc_clk_i,
  input  logic                    adc_rstn_i,
  input  logic                    cfg_we_i,
  input  logic [$clog2(SEG)-1:0]  cfg_addr_i,
  input  logic [CH*DW-1:0]        cfg_dat_i,
  input  logic [CH-1:0]           cfg_vmask_i,
  input  logic [CW-1:0]           cfg_dur_i,
  input  logic [$clog2(SEG):0]    num_seg_i,
  input  logic                    loop_i,
  input  logic                    start_i,
  input  logic                    stop_i,
  output logic [CH*DW-1:0]        dat_o,
  output logic [CH-1:0]           vld_o,
  output logic [$clog2(SEG)-1:0]  seg_o,
  output logic                    run_o,
  output logic                    done_o
);

  localparam int AW = $clog2(SEG);
  localparam int NW = AW + 1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e state_q, state_d;

  // Segment table; deliberately not reset so a programmed sequence survives
  // a reset of the sequencer.
  logic [CH*DW-1:0] tbl_dat_q [SEG];
  logic [CH*DW-1:0] tbl_dat_d [SEG];
  logic [CH-1:0]    tbl_vm_q  [SEG];
  logic [CH-1:0]    tbl_vm_d  [SEG];
  logic [CW-1:0]    tbl_dur_q [SEG];
  logic [CW-1:0]    tbl_dur_d [SEG];

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [NW-1:0]    num_seg_q, num_seg_d;
  logic             loop_q, loop_d;
  logic [CH*DW-1:0] dat_q, dat_d;
  logic [CH-1:0]    vld_q, vld_d;
  logic [AW-1:0]    seg_q, seg_d;
  logic             done_q, done_d;

  logic             start_ok;
  logic             seg_last;
  logic             load_en;
  logic [AW-1:0]    load_idx;
  logic [CW-1:0]    load_dur;

  always_comb begin
    tbl_dat_d = tbl_dat_q;
    tbl_vm_d  = tbl_vm_q;
    tbl_dur_d = tbl_dur_q;
    if (cfg_we_i && (int'(cfg_addr_i) < SEG)) begin
      tbl_dat_d[cfg_addr_i] = cfg_dat_i;
      tbl_vm_d[cfg_addr_i]  = cfg_vmask_i;
      tbl_dur_d[cfg_addr_i] = cfg_dur_i;
    end
  end

  always_ff @(posedge adc_clk_i) begin
    tbl_dat_q <= tbl_dat_d;
    tbl_vm_q  <= tbl_vm_d;
    tbl_dur_q <= tbl_dur_d;
  end

  assign start_ok = start_i && !stop_i && (num_seg_i != '0) &&
                    (int'(num_seg_i) <= SEG);
  assign seg_last = (({1'b0, seg_q} + NW'(1)) == num_seg_q);

  // cnt_q holds the clocks remaining in the current segment minus one, so a
  // segment advances on the clock after the counter reaches zero.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    num_seg_d = num_seg_q;
    loop_d    = loop_q;
    dat_d     = dat_q;
    vld_d     = vld_q;
    seg_d     = seg_q;
    done_d    = 1'b0;
    load_en   = 1'b0;
    load_idx  = '0;
    load_dur  = '0;

    case (state_q)
      IDLE: begin
        if (start_ok) begin
          state_d   = RUN;
          num_seg_d = num_seg_i;
          loop_d    = loop_i;
          load_en   = 1'b1;
          load_idx  = '0;
        end
      end
      RUN: begin
        if (stop_i) begin
          state_d = IDLE;
          vld_d   = '0;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else if (!seg_last) begin
          load_en  = 1'b1;
          load_idx = seg_q + AW'(1);
        end else if (loop_q) begin
          load_en  = 1'b1;
          load_idx = '0;
        end else begin
          state_d = IDLE;
          vld_d   = '0;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (load_en) begin
      load_dur = tbl_dur_q[load_idx];
      dat_d    = tbl_dat_q[load_idx];
      vld_d    = tbl_vm_q[load_idx];
      seg_d    = load_idx;
      cnt_d    = (load_dur == '0) ? '0 : (load_dur - CW'(1));
    end
  end

  always_ff @(posedge adc_clk_i) begin
    if (!adc_rstn_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      num_seg_q <= '0;
      loop_q    <= 1'b0;
      dat_q     <= '0;
      vld_q     <= '0;
      seg_q     <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      num_seg_q <= num_seg_d;
      loop_q    <= loop_d;
      dat_q     <= dat_d;
      vld_q     <= vld_d;
      seg_q     <= seg_d;
      done_q    <= done_d;
    end
  end

  assign dat_o  = dat_q;
  assign vld_o  = vld_q;
  assign seg_o  = seg_q;
  assign run_o  = (state_q == RUN);
  assign done_o = done_q;

endmodule

// File: tb/tb_adc_stim_sequencer.sv
// Directed bench for adc_stim_sequencer: reset, step sequence, looping with
// zero-length segments, stop priority, live table rewrite and mid-run reset.
module tb_adc_stim_sequencer;

  localparam int DW  = 14;
  localparam int CH  = 2;
  localparam int SEG = 8;
  localparam int CW  = 32;

  logic                   clk;
  logic                   rstn;
  logic                   cfg_we_i;
  logic [2:0]             cfg_addr_i;
  logic [CH*DW-1:0]       cfg_dat_i;
  logic [CH-1:0]          cfg_vmask_i;
  logic [CW-1:0]          cfg_dur_i;
  logic [3:0]             num_seg_i;
  logic                   loop_i;
  logic                   start_i;
  logic                   stop_i;
  logic [CH*DW-1:0]       dat_o;
  logic [CH-1:0]          vld_o;
  logic [2:0]             seg_o;
  logic                   run_o;
  logic                   done_o;

  int total = 0;
  int bad   = 0;

  adc_stim_sequencer #(.DW(DW), .CH(CH), .SEG(SEG), .CW(CW)) dut (
    .adc_clk_i   (clk),
    .adc_rstn_i  (rstn),
    .cfg_we_i    (cfg_we_i),
    .cfg_addr_i  (cfg_addr_i),
    .cfg_dat_i   (cfg_dat_i),
    .cfg_vmask_i (cfg_vmask_i),
    .cfg_dur_i   (cfg_dur_i),
    .num_seg_i   (num_seg_i),
    .loop_i      (loop_i),
    .start_i     (start_i),
    .stop_i      (stop_i),
    .dat_o       (dat_o),
    .vld_o       (vld_o),
    .seg_o       (seg_o),
    .run_o       (run_o),
    .done_o      (done_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [CH*DW-1:0] pk(input logic [DW-1:0] c0, input logic [DW-1:0] c1);
    return {c1, c0};
  endfunction

  task automatic wr_seg(input int a, input logic [DW-1:0] c0, input logic [DW-1:0] c1,
                        input logic [1:0] vm, input logic [31:0] dur);
    cfg_we_i    = 1'b1;
    cfg_addr_i  = a[2:0];
    cfg_dat_i   = pk(c0, c1);
    cfg_vmask_i = vm;
    cfg_dur_i   = dur;
    step();
    cfg_we_i    = 1'b0;
  endtask

  task automatic do_start(input int n, input logic lp);
    num_seg_i = n[3:0];
    loop_i    = lp;
    start_i   = 1'b1;
    step();
    start_i   = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) step();
    total++; if (dat_o !== '0)   begin bad++; $display("FAIL reset_dat got=%h exp=0", dat_o); end
    total++; if (vld_o !== '0)   begin bad++; $display("FAIL reset_vld got=%b exp=00", vld_o); end
    total++; if (seg_o !== '0)   begin bad++; $display("FAIL reset_seg got=%0d exp=0", seg_o); end
    total++; if (run_o !== 1'b0) begin bad++; $display("FAIL reset_run got=%b exp=0", run_o); end
    total++; if (done_o !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done_o); end
    rstn = 1'b1;
    step();
    do_start(0, 1'b0);
    total++; if (run_o !== 1'b0) begin bad++; $display("FAIL start_nseg0 run got=%b exp=0", run_o); end
    step();
    total++; if (run_o !== 1'b0) begin bad++; $display("FAIL start_nseg0_late run got=%b exp=0", run_o); end
    do_start(9, 1'b0);
    total++; if (run_o !== 1'b0) begin bad++; $display("FAIL start_nseg9 run got=%b exp=0", run_o); end
  endtask

  task automatic test_two_step();
    int bad_cyc;
    logic [CH*DW-1:0] ed;
    logic [1:0] ev;
    logic [2:0] es;
    bad_cyc = 0;
    wr_seg(0, 14'h123, 14'h123, 2'b11, 1000);
    wr_seg(1, 14'h423, 14'h423, 2'b00, 500);
    do_start(2, 1'b0);
    for (int k = 1; k <= 1500; k++) begin
      if (k > 1) step();
      if (k <= 1000) begin ed = pk(14'h123, 14'h123); ev = 2'b11; es = 3'd0; end
      else           begin ed = pk(14'h423, 14'h423); ev = 2'b00; es = 3'd1; end
      if (dat_o !== ed || vld_o !== ev || seg_o !== es || run_o !== 1'b1 || done_o !== 1'b0)
        bad_cyc++;
    end
    total++; if (bad_cyc !== 0) begin bad++; $display("FAIL two_step_body bad_cycles got=%0d exp=0", bad_cyc); end
    step();
    total++; if (done_o !== 1'b1) begin bad++; $display("FAIL two_step_done got=%b exp=1", done_o); end
    total++; if (run_o !== 1'b0)  begin bad++; $display("FAIL two_step_run_end got=%b exp=0", run_o); end
    total++; if (vld_o !== 2'b00) begin bad++; $display("FAIL two_step_vld_end got=%b exp=00", vld_o); end
    total++; if (dat_o !== pk(14'h423, 14'h423)) begin bad++; $display("FAIL two_step_dat_hold got=%h exp=%h", dat_o, pk(14'h423, 14'h423)); end
    step();
    total++; if (done_o !== 1'b0) begin bad++; $display("FAIL two_step_done_once got=%b exp=0", done_o); end
  endtask

  task automatic test_loop_dur0();
    logic [CH*DW-1:0] ed [3];
    logic [1:0] ev [3];
    int pat [4];
    int s;
    ed[0] = pk(14'h011, 14'h012); ev[0] = 2'b01;
    ed[1] = pk(14'h021, 14'h022); ev[1] = 2'b10;
    ed[2] = pk(14'h031, 14'h032); ev[2] = 2'b11;
    pat[0] = 0; pat[1] = 0; pat[2] = 1; pat[3] = 2;
    wr_seg(0, 14'h011, 14'h012, 2'b01, 2);
    wr_seg(1, 14'h021, 14'h022, 2'b10, 0);
    wr_seg(2, 14'h031, 14'h032, 2'b11, 1);
    do_start(3, 1'b1);
    for (int k = 1; k <= 12; k++) begin
      if (k > 1) step();
      s = pat[(k - 1) % 4];
      total++;
      if (seg_o !== s[2:0] || dat_o !== ed[s] || vld_o !== ev[s] || run_o !== 1'b1 || done_o !== 1'b0) begin
        bad++;
        $display("FAIL loop_k%0d got seg=%0d dat=%h vld=%b run=%b done=%b exp seg=%0d dat=%h vld=%b run=1 done=0",
                 k, seg_o, dat_o, vld_o, run_o, done_o, s, ed[s], ev[s]);
      end
    end
    stop_i = 1'b1;
    step();
    stop_i = 1'b0;
    total++; if (run_o !== 1'b0 || done_o !== 1'b0) begin bad++; $display("FAIL loop_stop got run=%b done=%b exp 0 0", run_o, done_o); end
  endtask

  task automatic test_live_rewrite();
    wr_seg(0, 14'h051, 14'h052, 2'b11, 3);
    wr_seg(1, 14'h061, 14'h062, 2'b10, 0);
    wr_seg(2, 14'h071, 14'h072, 2'b01, 1);
    do_start(3, 1'b1);
    wr_seg(1, 14'h223, 14'h223, 2'b10, 0);
    total++; if (seg_o !== 3'd0 || dat_o !== pk(14'h051, 14'h052)) begin bad++; $display("FAIL live_seg0_k2 got seg=%0d dat=%h exp seg=0 dat=%h", seg_o, dat_o, pk(14'h051, 14'h052)); end
    wr_seg(0, 14'h3aa, 14'h3ab, 2'b11, 3);
    total++; if (seg_o !== 3'd0 || dat_o !== pk(14'h051, 14'h052)) begin bad++; $display("FAIL live_cur_unchanged got seg=%0d dat=%h exp seg=0 dat=%h", seg_o, dat_o, pk(14'h051, 14'h052)); end
    step();
    total++; if (seg_o !== 3'd1 || dat_o !== pk(14'h223, 14'h223)) begin bad++; $display("FAIL live_seg1_new got seg=%0d dat=%h exp seg=1 dat=%h", seg_o, dat_o, pk(14'h223, 14'h223)); end
    step();
    total++; if (seg_o !== 3'd2 || dat_o !== pk(14'h071, 14'h072)) begin bad++; $display("FAIL live_seg2 got seg=%0d dat=%h exp seg=2 dat=%h", seg_o, dat_o, pk(14'h071, 14'h072)); end
    step();
    total++; if (seg_o !== 3'd0 || dat_o !== pk(14'h3aa, 14'h3ab)) begin bad++; $display("FAIL live_seg0_reload got seg=%0d dat=%h exp seg=0 dat=%h", seg_o, dat_o, pk(14'h3aa, 14'h3ab)); end
    stop_i = 1'b1;
    step();
    stop_i = 1'b0;
    total++; if (run_o !== 1'b0) begin bad++; $display("FAIL live_stop run got=%b exp=0", run_o); end
  endtask

  task automatic test_stop();
    wr_seg(0, 14'h101, 14'h102, 2'b11, 2);
    wr_seg(1, 14'h201, 14'h202, 2'b11, 3);
    wr_seg(2, 14'h301, 14'h302, 2'b01, 2);
    do_start(3, 1'b0);
    step();
    step();
    total++; if (seg_o !== 3'd1) begin bad++; $display("FAIL stop_pre_seg got=%0d exp=1", seg_o); end
    stop_i = 1'b1;
    step();
    stop_i = 1'b0;
    total++; if (run_o !== 1'b0)  begin bad++; $display("FAIL stop_run got=%b exp=0", run_o); end
    total++; if (vld_o !== 2'b00) begin bad++; $display("FAIL stop_vld got=%b exp=00", vld_o); end
    total++; if (done_o !== 1'b0) begin bad++; $display("FAIL stop_done got=%b exp=0", done_o); end
    total++; if (seg_o !== 3'd1 || dat_o !== pk(14'h201, 14'h202)) begin bad++; $display("FAIL stop_hold got seg=%0d dat=%h exp seg=1 dat=%h", seg_o, dat_o, pk(14'h201, 14'h202)); end
    step();
    total++; if (done_o !== 1'b0 || run_o !== 1'b0) begin bad++; $display("FAIL stop_after got done=%b run=%b exp 0 0", done_o, run_o); end
    num_seg_i = 4'd3;
    start_i   = 1'b1;
    stop_i    = 1'b1;
    step();
    start_i   = 1'b0;
    stop_i    = 1'b0;
    total++; if (run_o !== 1'b0 || vld_o !== 2'b00) begin bad++; $display("FAIL start_stop_same got run=%b vld=%b exp 0 00", run_o, vld_o); end
    step();
    total++; if (run_o !== 1'b0) begin bad++; $display("FAIL start_stop_late run got=%b exp=0", run_o); end
  endtask

  task automatic test_reset_mid_run();
    do_start(3, 1'b0);
    repeat (5) step();
    total++; if (seg_o !== 3'd2 || run_o !== 1'b1) begin bad++; $display("FAIL rmid_pre got seg=%0d run=%b exp seg=2 run=1", seg_o, run_o); end
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    total++; if (dat_o !== '0)    begin bad++; $display("FAIL rmid_dat got=%h exp=0", dat_o); end
    total++; if (vld_o !== '0)    begin bad++; $display("FAIL rmid_vld got=%b exp=00", vld_o); end
    total++; if (seg_o !== '0)    begin bad++; $display("FAIL rmid_seg got=%0d exp=0", seg_o); end
    total++; if (run_o !== 1'b0)  begin bad++; $display("FAIL rmid_run got=%b exp=0", run_o); end
    total++; if (done_o !== 1'b0) begin bad++; $display("FAIL rmid_done got=%b exp=0", done_o); end
    step();
    total++; if (done_o !== 1'b0 || run_o !== 1'b0) begin bad++; $display("FAIL rmid_after got done=%b run=%b exp 0 0", done_o, run_o); end
    do_start(3, 1'b0);
    total++; if (dat_o !== pk(14'h101, 14'h102) || vld_o !== 2'b11 || seg_o !== 3'd0 || run_o !== 1'b1) begin
      bad++;
      $display("FAIL rmid_restart got dat=%h vld=%b seg=%0d run=%b exp dat=%h vld=11 seg=0 run=1",
               dat_o, vld_o, seg_o, run_o, pk(14'h101, 14'h102));
    end
    stop_i = 1'b1;
    step();
    stop_i = 1'b0;
  endtask

  initial begin
    rstn        = 1'b0;
    cfg_we_i    = 1'b0;
    cfg_addr_i  = '0;
    cfg_dat_i   = '0;
    cfg_vmask_i = '0;
    cfg_dur_i   = '0;
    num_seg_i   = '0;
    loop_i      = 1'b0;
    start_i     = 1'b0;
    stop_i      = 1'b0;
    test_reset();
    test_two_step();
    test_loop_dur0();
    test_live_rewrite();
    test_stop();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
